// File: rtl/decoder24_hold.sv
// decoder24_hold: sequential 2-to-4 decoder with a programmable hold time.
// Accepts a 2-bit code over valid/ready, drives the one-hot y for HOLD_CYCLES
// cycles (done pulses on the last one), then returns to idle.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        block enable; low aborts a hold and blocks acceptance
//   in_valid  in_code is valid this cycle
//   in_code   code to decode (0..3)
//   in_ready  combinational: block can accept a code this cycle
//   y         registered one-hot output, 4'b0000 when idle
//   y_valid   y carries a decoded value
//   done      one-cycle pulse on the final hold cycle
//   count     accepted-code counter, wraps modulo 2^CNT_W
module decoder24_hold #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [1:0]       in_code,
  output logic             in_ready,
  output logic [3:0]       y,
  output logic             y_valid,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned HOLD_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;

  // Ready only when idle, enabled and out of reset.
  assign in_ready = (state == IDLE) && en && rst_n;
  assign accept   = in_valid && in_ready;

  // FSM with registered outputs; done is set one cycle early so it lands
  // on the final hold cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      y        <= 4'b0000;
      y_valid  <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          y       <= 4'b0000;
          y_valid <= 1'b0;
          done    <= 1'b0;
          if (accept) begin
            y        <= 4'b0001 << in_code;
            y_valid  <= 1'b1;
            done     <= (HOLD_CYCLES == 1);
            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            count    <= count + CNT_W'(1);
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!en) begin
            // Abort: release immediately, no done pulse, count untouched.
            y        <= 4'b0000;
            y_valid  <= 1'b0;
            done     <= 1'b0;
            hold_cnt <= '0;
            state    <= IDLE;
          end else if (hold_cnt == '0) begin
            y       <= 4'b0000;
            y_valid <= 1'b0;
            done    <= 1'b0;
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            done     <= (hold_cnt == HOLD_W'(1));
          end
        end
        default: begin
          state   <= IDLE;
          y       <= 4'b0000;
          y_valid <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder24_hold.sv
module tb_decoder24_hold;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, in_valid;
  logic [1:0] in_code;
  logic       in_ready, y_valid, done;
  logic [3:0] y;
  logic [7:0] count;

  logic       en_b, in_valid_b;
  logic [1:0] in_code_b;
  logic       in_ready_b, y_valid_b, done_b;
  logic [3:0] y_b;
  logic [1:0] count_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder24_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .y(y), .y_valid(y_valid), .done(done), .count(count)
  );

  decoder24_hold #(.HOLD_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .in_valid(in_valid_b), .in_code(in_code_b),
    .in_ready(in_ready_b), .y(y_b), .y_valid(y_valid_b), .done(done_b), .count(count_b)
  );

  typedef struct {
    logic       en;
    logic       v;
    logic [1:0] code;
    logic [3:0] y;
    logic       yv;
    logic       done;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] oh [4];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic e, input logic v, input logic [1:0] c,
                              input logic [3:0] ey, input logic eyv, input logic ed,
                              input logic er, input logic [7:0] ec);
    vec_t r;
    r.en = e; r.v = v; r.code = c; r.y = ey; r.yv = eyv; r.done = ed; r.rdy = er; r.cnt = ec;
    tbl.push_back(r);
  endfunction

  initial begin
    logic [1:0] cb [6];
    oh[0] = 4'b0001; oh[1] = 4'b0010; oh[2] = 4'b0100; oh[3] = 4'b1000;
    cb[0] = 2'd0; cb[1] = 2'd1; cb[2] = 2'd2; cb[3] = 2'd3; cb[4] = 2'd0; cb[5] = 2'd1;

    // Each row: inputs driven before an edge, expected outputs seen in that same cycle.
    // Codes 0..3 with a 4-cycle hold.
    for (int c = 0; c < 4; c++) begin
      add(1, 1, 2'(c), 4'b0000, 0, 0, 1, 8'(c));
      for (int k = 0; k < 4; k++)
        add(1, 0, 2'(c), oh[c], 1, (k == 3), 0, 8'(c + 1));
    end
    add(1, 0, 0, 4'b0000, 0, 0, 1, 8'd4);
    // Back-to-back: valid held with code 2, accept every 5 cycles.
    for (int r = 0; r < 15; r++) begin
      if (r % 5 == 0) add(1, 1, 2, 4'b0000, 0, 0, 1, 8'(4 + r / 5));
      else            add(1, 1, 2, 4'b0100, 1, (r % 5 == 4), 0, 8'(5 + r / 5));
    end
    add(1, 0, 2, 4'b0000, 0, 0, 1, 8'd7);
    // Abort on second hold cycle, then en low with valid high.
    add(1, 1, 3, 4'b0000, 0, 0, 1, 8'd7);
    add(1, 0, 3, 4'b1000, 1, 0, 0, 8'd8);
    add(0, 0, 3, 4'b1000, 1, 0, 0, 8'd8);
    for (int k = 0; k < 5; k++)
      add(0, 1, 1, 4'b0000, 0, 0, 0, 8'd8);
    add(1, 0, 1, 4'b0000, 0, 0, 1, 8'd8);

    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_code = 2'd0;
    en_b = 1'b0; in_valid_b = 1'b0; in_code_b = 2'd0;

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    en = 1'b1;
    #1;
    chk("rst_y", 0, 8'(y), 8'h00);
    chk("rst_y_valid", 0, 8'(y_valid), 8'h00);
    chk("rst_done", 0, 8'(done), 8'h00);
    chk("rst_count", 0, count, 8'h00);
    chk("rst_in_ready_low", 0, 8'(in_ready), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 0, 8'(in_ready), 8'h01);
    chk("rel_y", 0, 8'(y), 8'h00);
    chk("rel_count", 0, count, 8'h00);

    foreach (tbl[i]) begin
      @(negedge clk);
      en = tbl[i].en; in_valid = tbl[i].v; in_code = tbl[i].code;
      #1;
      chk("tbl_y", i, 8'(y), 8'(tbl[i].y));
      chk("tbl_y_valid", i, 8'(y_valid), 8'(tbl[i].yv));
      chk("tbl_done", i, 8'(done), 8'(tbl[i].done));
      chk("tbl_in_ready", i, 8'(in_ready), 8'(tbl[i].rdy));
      chk("tbl_count", i, count, tbl[i].cnt);
    end

    // Asynchronous reset while y=0010.
    @(negedge clk);
    en = 1'b1; in_valid = 1'b1; in_code = 2'd1;
    #1 chk("ar_ready", 0, 8'(in_ready), 8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("ar_y_pre", 0, 8'(y), 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_y", 0, 8'(y), 8'h00);
    chk("ar_y_valid", 0, 8'(y_valid), 8'h00);
    chk("ar_done", 0, 8'(done), 8'h00);
    chk("ar_count", 0, count, 8'h00);
    chk("ar_in_ready", 0, 8'(in_ready), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ar_release_ready", 0, 8'(in_ready), 8'h01);
    @(negedge clk);
    #1 chk("ar_idle_y", 0, 8'(y), 8'h00);

    // HOLD_CYCLES=1, CNT_W=2: accept every 2 cycles, y_valid and done together.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en_b = 1'b1; in_valid_b = 1'b1;
      if (i % 2 == 0) in_code_b = 2'((i / 2) % 4);
      #1;
      if (i % 2 == 0) begin
        chk("h1_y_idle", i, 8'(y_b), 8'h00);
        chk("h1_y_valid_idle", i, 8'(y_valid_b), 8'h00);
        chk("h1_done_idle", i, 8'(done_b), 8'h00);
        chk("h1_ready_idle", i, 8'(in_ready_b), 8'h01);
        chk("h1_count_idle", i, 8'(count_b), 8'(cb[i / 2]));
      end else begin
        chk("h1_y", i, 8'(y_b), 8'(oh[(i / 2) % 4]));
        chk("h1_y_valid", i, 8'(y_valid_b), 8'h01);
        chk("h1_done", i, 8'(done_b), 8'h01);
        chk("h1_ready", i, 8'(in_ready_b), 8'h00);
        chk("h1_count", i, 8'(count_b), 8'(cb[i / 2 + 1]));
      end
    end
    in_valid_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decoder24_hold.md
Name: decoder24_hold

Overview:
- Sequential 2-to-4 decoder; the inverse of the team's 4-to-2 encoder.
- Accepts a 2-bit code over a valid/ready handshake.
- Drives the matching one-hot 4-bit output for a programmable number of cycles, then releases it.
- Sits downstream of the encoder path. Used to drive one-hot select/LED lines that must stay stable for a minimum time.

Parameters:
- HOLD_CYCLES, default 4: cycles the one-hot output stays asserted per transaction. Legal range 1..255.
- CNT_W, default 8: width of the accepted-transaction counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable. Low aborts any hold in progress and blocks acceptance.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  2  code to decode: 0..3.
- in_ready  output  1  block can accept a code this cycle.
- y  output  4  registered one-hot output. 4'b0000 when idle.
- y_valid  output  1  y carries a decoded value.
- done  output  1  one-cycle pulse on the final hold cycle.
- count  output  CNT_W  number of accepted codes, wraps modulo 2^CNT_W.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0 and on release:
  - state=IDLE.
  - y=4'b0000, y_valid=0, done=0, count=0.
  - Internal hold counter = 0.
- in_ready is combinational: 1 iff state==IDLE and en==1 and rst_n==1.
- Accept = in_valid & in_ready, sampled at the rising clk edge.
- State machine has two states: IDLE and HOLD.
- IDLE:
  - y=0, y_valid=0.
  - On accept:
    - Next cycle y = 4'b0001 << in_code, so 0->0001, 1->0010, 2->0100, 3->1000.
    - y_valid=1, state=HOLD.
    - Hold counter loads HOLD_CYCLES-1.
    - count increments by 1.
  - in_code is captured only on accept. Changes at any other time are ignored.
- HOLD:
  - y and y_valid are held stable.
  - If en==0: abort. Next cycle y=0, y_valid=0, state=IDLE. No done pulse. count is not changed.
  - Else if hold counter==0:
    - done=1 this cycle.
    - Next cycle y=0, y_valid=0, done=0, state=IDLE.
  - Else the hold counter decrements by 1.
- Latency: accept edge to y valid is 1 cycle.
- y_valid is high for exactly HOLD_CYCLES consecutive cycles.
- done is high during the last of those cycles.
- in_ready returns high the cycle after the last hold cycle. Minimum spacing between accepts is HOLD_CYCLES+1 cycles.
- HOLD_CYCLES=1: the hold counter loads 0, so y_valid and done are high in the same single cycle.
- count wraps 2^CNT_W-1 -> 0 with no flag.
- done and y_valid are never high while y==0. y is always either 0 or exactly one-hot.
- in_valid held high while in_ready=0: nothing is accepted. The pending code is accepted on the first cycle in_ready=1 (standard handshake; the source must hold data stable).
- Reset asserted mid-HOLD: all outputs clear immediately, asynchronously, with no done pulse.
- en low in IDLE: in_ready=0, no accept, outputs stay 0.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release. Check y=0000, y_valid=0, done=0, count=0, in_ready=1 (with en=1).
- HOLD_CYCLES=4, en=1. Send codes 0,1,2,3, each accepted when in_ready=1.
  - Required y sequence: 0001, 0010, 0100, 1000, each for exactly 4 cycles, starting 1 cycle after accept.
  - done pulses on the 4th cycle of each.
  - in_ready=0 throughout each hold. count=4 at the end.
- Back-to-back: hold in_valid=1 with in_code=2 continuously.
  - Accepts occur every 5 cycles; y=0100 for 4 cycles, then 0000 for 1 cycle.
  - After 3 accepts, count=3.
- Abort: accept code 3, then drop en on the 2nd hold cycle.
  - Next cycle y=0000, y_valid=0, and no done pulse.
  - count stays at 1.
  - With en=0 and in_valid=1 applied for 5 cycles, in_ready stays 0 and no accept occurs.
- Asynchronous reset mid-hold: assert rst_n=0 between clock edges while y=0010. Outputs clear before the next edge; count=0.
- Parameter corners:
  - HOLD_CYCLES=1: y_valid and done are high in the same single cycle; accepts occur every 2 cycles.
  - CNT_W=2 with 5 accepts: count sequence 1,2,3,0,1.
